// File: rtl/alu_muldiv_pkg.sv
// Shared types for the multiply/divide unit: op encodings, FSM states and op-decode helpers.
package alu_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } mdop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } md_state_t;

  typedef logic [31:0] word_t;

  function automatic logic md_is_div(mdop_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(mdop_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_divider.sv
// Unsigned iterative radix-2 restoring divider: one quotient bit per cycle, WIDTH cycles after start.
module alu_muldiv_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             last,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   part;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
  assign part = {remainder, quotient[WIDTH-1]};
  assign fits = (part >= {1'b0, dvs});
  assign diff = part[WIDTH-1:0] - dvs;
  assign last = busy && (cnt == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy      <= 1'b0;
      cnt       <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      cnt       <= '0;
      dvs       <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (busy) begin
      if (fits) begin
        remainder <= diff;
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        remainder <= part[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
      if (cnt == LAST) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO. Define MDU_FAST_MUL_EN for a single-cycle
// combinational multiplier; otherwise multiply is iterative shift-add with divide timing.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  mdop_t            op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_t          state;
  logic [CW-1:0]      cnt;
  mdop_t              op_q;
  logic               q_neg, r_neg, dz;
  logic [WIDTH-1:0]   a_raw;
  logic [2*WIDTH-1:0] mul_acc, mul_mc;
  logic [WIDTH-1:0]   mul_mp;

  logic               launch, a_neg, b_neg, div_last, calc_last;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign busy   = (state != IDLE);
  assign launch = (state == IDLE) && start && !flush;
  assign a_neg  = md_is_signed(op) && a[WIDTH-1];
  assign b_neg  = md_is_signed(op) && b[WIDTH-1];
  assign mag_a  = a_neg ? -a : a;
  assign mag_b  = b_neg ? -b : b;

  alu_muldiv_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (launch && md_is_div(op)),
    .abort    (flush),
    .dividend (mag_a),
    .divisor  (mag_b),
    .last     (div_last),
    .quotient (quo),
    .remainder(rem)
  );

  assign calc_last = md_is_div(op_q) ? div_last : (cnt == LAST);
  assign prod      = q_neg ? -mul_acc : mul_acc;

  // Divide by zero bypasses sign correction so signed and unsigned give the same raw result.
  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (md_is_div(op_q)) begin
      if (dz) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_hi = r_neg ? -rem : rem;
        res_lo = q_neg ? -quo : quo;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      op_q    <= MD_MULT;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dz      <= 1'b0;
      a_raw   <= '0;
      mul_acc <= '0;
      mul_mc  <= '0;
      mul_mp  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (launch) begin
            op_q   <= op;
            q_neg  <= a_neg ^ b_neg;
            r_neg  <= a_neg;
            dz     <= (b == '0);
            a_raw  <= a;
            cnt    <= '0;
            mul_mc <= {{WIDTH{1'b0}}, mag_a};
            mul_mp <= mag_b;
`ifdef MDU_FAST_MUL_EN
            mul_acc <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
            state   <= md_is_div(op) ? CALC : FIN;
`else
            mul_acc <= '0;
            state   <= CALC;
`endif
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (!md_is_div(op_q) && mul_mp[0]) mul_acc <= mul_acc + mul_mc;
            mul_mc <= mul_mc << 1;
            mul_mp <= mul_mp >> 1;
            if (calc_last) begin
              state <= FIN;
              cnt   <= '0;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: stimulus pushes model results, a negedge monitor pops on done.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  mdop_t        op = MD_MULT;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
  } exp_t;

  exp_t sbq[$];
  exp_t mexp;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc++;

  // Reference: 64-bit arithmetic and SV signed division (truncates toward zero).
  // due = index of the rising edge after which done is high (start edge index + WIDTH + 1).
  function automatic exp_t model(mdop_t o, logic [W-1:0] x, logic [W-1:0] y, int t0);
    exp_t        e;
    logic [63:0] u;
    e.due = t0 + W + 1;
    case (o)
      MD_MULT: begin
        u = longint'($signed(x)) * longint'($signed(y));
        e.hi = u[63:32]; e.lo = u[31:0];
`ifdef MDU_FAST_MUL_EN
        e.due = t0 + 1;
`endif
      end
      MD_MULTU: begin
        u = {32'b0, x} * {32'b0, y};
        e.hi = u[63:32]; e.lo = u[31:0];
`ifdef MDU_FAST_MUL_EN
        e.due = t0 + 1;
`endif
      end
      MD_DIV: begin
        if (y == 0) begin
          e.lo = '1; e.hi = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 0;
        end else begin
          e.lo = 32'($signed(x) / $signed(y));
          e.hi = 32'($signed(x) % $signed(y));
        end
      end
      default: begin
        if (y == 0) begin
          e.lo = '1; e.hi = x;
        end else begin
          e.lo = x / y; e.hi = x % y;
        end
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s got %h required %h", nm, act, req);
    end
  endtask

  task automatic issue(input mdop_t o, input logic [W-1:0] x, input logic [W-1:0] y, input bit scored);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    if (scored) sbq.push_back(model(o, x, y, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      n_vec++; n_err++;
      $display("FAIL busy_timeout busy=%b after %0d cycles, required 0", busy, n);
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (resetn && done) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL spurious_done hi=%h lo=%h at edge %0d, required no done", hi, lo, cyc);
      end else begin
        mexp = sbq.pop_front();
        if (hi !== mexp.hi || lo !== mexp.lo || cyc != mexp.due) begin
          n_err++;
          $display("FAIL result hi=%h lo=%h edge=%0d required hi=%h lo=%h edge=%0d",
                   hi, lo, cyc, mexp.hi, mexp.lo, mexp.due);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] lo_before;
    mdop_t        o;

    repeat (2) @(negedge clk);
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    resetn = 1'b1;

    issue(MD_MULT,  32'hFFFF_FFFF, 32'd2, 1); wait_idle();
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1); wait_idle();
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1); wait_idle();
    issue(MD_DIVU,  32'd7,         32'd2, 1); wait_idle();
    issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1); wait_idle();
    issue(MD_DIVU,  32'd7,         32'd0, 1); wait_idle();
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd0, 1); wait_idle();

    @(negedge clk); lo_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk); lo_we = 1'b0;
    chk("mtlo_lo", lo, 32'hABCD);
    chk("mtlo_busy", W'(busy), '0);

    // Flush mid-divide: HI/LO untouched, no done (monitor flags any).
    @(negedge clk); hi_we = 1'b1; wdata = 32'h11;
    @(negedge clk); hi_we = 1'b0;
    chk("mthi_hi", hi, 32'h11);
    lo_before = lo;
    issue(MD_DIVU, 32'd100, 32'd3, 0);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_busy", W'(busy), '0);
    repeat (40) @(negedge clk);
    chk("flush_hi", hi, 32'h11);
    chk("flush_lo", lo, lo_before);

    // Reset mid-divide discards the op and clears HI/LO.
    @(negedge clk); hi_we = 1'b1; wdata = 32'h22;
    @(negedge clk); hi_we = 1'b0;
    issue(MD_DIVU, 32'd100, 32'd3, 0);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midreset_hi", hi, '0);
    chk("midreset_lo", lo, '0);
    chk("midreset_busy", W'(busy), '0);
    @(negedge clk); resetn = 1'b1;
    repeat (40) @(negedge clk);
    chk("postreset_hi", hi, '0);

    // Start and MTHI while busy are both ignored.
`ifdef MDU_FAST_MUL_EN
    o = MD_DIVU;
`else
    o = MD_MULTU;
`endif
    issue(o, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    repeat (1) @(negedge clk);
    start = 1'b1; op = MD_DIV; a = 32'd50; b = 32'd7; hi_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk); start = 1'b0; hi_we = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    chk("ignored_start_busy", W'(busy), '0);

    for (int i = 0; i < 40; i++) begin
      o = mdop_t'($urandom_range(0, 3));
      issue(o, pick(), pick(), 1);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", W'(sbq.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised multi-cycle multiply/divide unit; extends the combinational ALU with MIPS MULT/MULTU/DIV/DIVU.
- Owns the architectural HI/LO registers.
- Sits beside the ALU in execute; the core stalls on busy.
- Width is generic. Divide is iterative radix-2 restoring. Multiply is iterative shift-add, or single-cycle when the optional feature is enabled.

Parameters:
WIDTH, 32, operand/HI/LO width (>=4)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  launch op (sampled only when busy=0)
op  in  2  mdop_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
a  in  WIDTH  multiplicand/dividend
b  in  WIDTH  multiplier/divisor
flush  in  1  abort in-flight op
hi_we  in  1  MTHI write
lo_we  in  1  MTLO write
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  op in flight
done  out  1  one-cycle pulse: new HI/LO visible this cycle
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset: async, active-low. On assertion: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Mid-operation reset discards the op.
- FSM states: IDLE, CALC, FIN.
  - IDLE & start & !flush -> CALC. Latch |a|, |b|, op, sign flags; counter=0.
  - CALC: one iteration per cycle. After WIDTH iterations -> FIN.
  - FIN: sign-correct; on the edge leaving FIN write HI/LO -> IDLE.
- busy = (state != IDLE). done is registered: high exactly the one cycle after leaving FIN; hi/lo hold the new values in that same cycle.
- Latency: start edge at T -> done high in cycle T+WIDTH+2 (34 cycles for WIDTH=32).
- start while busy: ignored, no queueing.
- Multiply: 2*WIDTH-bit product; hi=upper half, lo=lower half.
  - MULT: signed via magnitudes; negate product if sign(a)^sign(b).
  - MULTU: unsigned.
- Divide: lo=quotient, hi=remainder, truncation toward zero.
  - Quotient negative iff sign(a)^sign(b). Remainder takes the sign of the dividend.
  - Divide by zero (no trap): lo={WIDTH{1}}, hi=a (unsigned path). Signed divide by zero gives the same values using raw a.
  - Signed overflow (most-negative / -1): lo=most-negative, hi=0, wrap.
- flush: any cycle while busy, next state=IDLE, no done, HI/LO unchanged. flush together with start in IDLE: start ignored.
- hi_we/lo_we: accepted only when busy=0, written at the next edge. Ignored while busy.
  - Same-cycle start + hi_we: the write happens; the op result later overwrites it.
  - A write in the done cycle is legal and overrides.

Optional Feature:
MDU_FAST_MUL_EN
- Defined: MULT/MULTU use a single-cycle combinational multiplier. IDLE -> FIN directly; done in cycle T+2. Divide is unchanged.
- Undefined: multiply is iterative, WIDTH CALC cycles, same timing as divide.

Decomposition:
- Shared package (mips.svh): mdop_t enum (2 bits), MD_* encodings, md_state_t (IDLE/CALC/FIN).
- word_t covers WIDTH=32 uses; the module itself uses logic [WIDTH-1:0].
- One natural sub-module: muldiv_divider (iterative restoring divider core: start/busy/quotient/remainder, unsigned). alu_muldiv handles signs, the multiply path, the FSM and HI/LO.

Test Plan:
- MULT a=0xFFFFFFFF b=2 -> done at T+34 (T+2 with MDU_FAST_MUL_EN); hi=0xFFFFFFFF lo=0xFFFFFFFE. Same operands with MULTU -> hi=0x00000001 lo=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3 hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
- DIVU a=7 b=0 -> lo=0xFFFFFFFF hi=7; done asserted normally.
- Preload hi=0x11 via hi_we, start DIVU, pulse flush at cycle 5 -> busy=0 next cycle, no done, hi stays 0x11. Repeat with resetn low at cycle 5 -> hi=lo=0.
- Start MULTU, assert start with new operands and hi_we at cycle 3 -> both ignored; single done; result from the first operands.
- Idle: lo_we with wdata=0xABCD -> lo=0xABCD next cycle, busy stays 0, no done.
